// File: rtl/prm_accum_pkg.sv
// Shared types and helpers for the PRM edge-mask accumulator: state encoding,
// safe clog2 and a word popcount.
package prm_accum_pkg;

    localparam int VOX_W_DEF = 15;
    // Widest read word the popcount helper handles; narrower words are zero-extended.
    localparam int POP_MAX_W = 64;

    typedef enum logic {
        ACC   = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Never returns 0 so a single-word bank still gets a 1-bit address.
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) c = c + 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/prm_edge_mask_accum_popcnt.sv
// Combinational popcount of one read-width word of the committed edge bitmap.
module prm_mask_popcnt
    import prm_accum_pkg::*;
#(
    parameter  int RD_W = 16,
    localparam int PC_W = clog2_safe(RD_W + 1)
)(
    input  logic [RD_W-1:0] i_word,
    output logic [PC_W-1:0] o_count
);

    logic [POP_MAX_W-1:0] w_ext;

    assign w_ext   = POP_MAX_W'(i_word);
    assign o_count = PC_W'(popcount(w_ext));

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Streams voxel codes into the edge-checker bank, ORs the returned masks over a
// frame, commits the blocked-edge bitmap and counts blocked edges word-serially.
module prm_edge_mask_accum
    import prm_accum_pkg::*;
#(
    parameter  int VOX_W  = VOX_W_DEF,
    parameter  int EDGE_W = 64,
    parameter  int RD_W   = 16,
    parameter  int CNT_W  = 16,
    localparam int WORDS  = EDGE_W / RD_W,
    localparam int AW     = clog2_safe(WORDS),
    localparam int PC_W   = clog2_safe(RD_W + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              vox_valid,
    output logic              vox_ready,
    input  logic [VOX_W-1:0]  vox_code,
    input  logic              vox_last,
    input  logic              abort,
    output logic [VOX_W-1:0]  chk_code,
    input  logic [EDGE_W-1:0] chk_mask,
    input  logic [AW-1:0]     rd_addr,
    output logic [RD_W-1:0]   rd_data,
    output logic              frame_valid,
    output logic              frame_done,
    output logic [CNT_W-1:0]  vox_cnt,
    output logic [CNT_W-1:0]  blocked_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pipe_valid;
    logic              r_pipe_last;
    logic [VOX_W-1:0]  r_chk_code;
    logic [EDGE_W-1:0] r_acc;
    logic [EDGE_W-1:0] r_out_bank;
    logic [CNT_W-1:0]  r_run_cnt;
    logic [CNT_W-1:0]  r_vox_cnt;
    logic [CNT_W-1:0]  r_blocked_cnt;
    logic [CNT_W-1:0]  r_sum;
    logic [AW-1:0]     r_idx;
    logic              r_frame_valid;
    logic              r_frame_done;
    logic [RD_W-1:0]   r_rd_data;

    logic              w_vox_ready;
    logic              w_accept;
    logic              w_commit;
    logic              w_count_last;
    logic [PC_W-1:0]   w_pop;
    logic [RD_W-1:0]   w_words [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign w_words[g] = r_out_bank[g*RD_W +: RD_W];
    end

    prm_mask_popcnt #(
        .RD_W    (RD_W)
    ) u_popcnt (
        .i_word  (w_words[r_idx]),
        .o_count (w_pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_state_nxt;
    end

    // A committing last beat blocks intake for one cycle; abort wins over that commit.
    always_comb begin
        w_state_nxt  = r_state;
        w_vox_ready  = 1'b0;
        w_commit     = 1'b0;
        w_count_last = 1'b0;
        case (r_state)
            ACC: begin
                w_vox_ready = !(r_pipe_valid && r_pipe_last) && !abort;
                w_commit    = r_pipe_valid && r_pipe_last && !abort;
                if (w_commit) w_state_nxt = COUNT;
            end
            COUNT: begin
                w_count_last = (r_idx == AW'(WORDS - 1));
                if (w_count_last) w_state_nxt = ACC;
            end
            default: w_state_nxt = ACC;
        endcase
    end

    assign w_accept = vox_valid && w_vox_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_code   <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_last  <= 1'b0;
            r_run_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_chk_code   <= vox_code;
                r_pipe_valid <= 1'b1;
                r_pipe_last  <= vox_last;
            end else begin
                r_pipe_valid <= 1'b0;
                r_pipe_last  <= 1'b0;
            end
            if ((r_state == ACC) && abort)             r_run_cnt <= '0;
            else if (w_commit)                         r_run_cnt <= '0;
            else if (w_accept && (r_run_cnt != '1))    r_run_cnt <= r_run_cnt + CNT_W'(1);
        end
    end

    // Stage 2: fold the checker result of the registered code into the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc         <= '0;
            r_out_bank    <= '0;
            r_vox_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            if ((r_state == ACC) && abort) r_acc <= '0;
            else if (r_pipe_valid)         r_acc <= r_pipe_last ? '0 : (r_acc | chk_mask);
            if (w_commit) begin
                r_out_bank    <= r_acc | chk_mask;
                r_vox_cnt     <= r_run_cnt;
                r_frame_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_sum         <= '0;
            r_blocked_cnt <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_idx <= '0;
                r_sum <= '0;
            end else if (r_state == COUNT) begin
                r_idx <= r_idx + AW'(1);
                r_sum <= r_sum + CNT_W'(w_pop);
            end
            if (w_count_last) r_blocked_cnt <= r_sum + CNT_W'(w_pop);
            r_frame_done <= w_count_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_rd_data <= '0;
        else if ({1'b0, rd_addr} < (AW + 1)'(WORDS))      r_rd_data <= w_words[rd_addr];
        else                                              r_rd_data <= '0;
    end

    assign vox_ready   = w_vox_ready;
    assign chk_code    = r_chk_code;
    assign rd_data     = r_rd_data;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign vox_cnt     = r_vox_cnt;
    assign blocked_cnt = r_blocked_cnt;

endmodule
